// File: rtl/board_pkg.sv
// Shared board constants and the scan FSM state type
// for the cell scanner and its output register.
package board_pkg;

  localparam int NCELLS_DEF = 9;
  localparam int WIDTH_DEF  = 8;
  localparam int IDXW_DEF   = 4;

  localparam logic [7:0] CELL_EMPTY = 8'h00;
  localparam logic [7:0] CELL_X     = 8'h01;
  localparam logic [7:0] CELL_O     = 8'h02;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } scan_state_e;

endpackage

// File: rtl/board_out_reg.sv
// Single-stage valid/ready output register
// carrying cell word, index and last flag.
module board_out_reg
  import board_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int IDXW  = IDXW_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic [IDXW-1:0]  index_i,
  input  logic             last_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic [IDXW-1:0]  index_o,
  output logic             last_o,
  output logic             valid_o,
  output logic             can_load_o
);

  logic [WIDTH-1:0] data_q;
  logic [IDXW-1:0]  index_q;
  logic             last_q;
  logic             valid_q;

  assign can_load_o = !valid_q || ready_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      index_q <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end else if (can_load_o) begin
      valid_q <= load_i;
      // payload only moves on a real load so rejected selects leave it intact
      if (load_i) begin
        data_q  <= data_i;
        index_q <= index_i;
        last_q  <= last_i;
      end
    end
  end

  assign data_o  = data_q;
  assign index_o = index_q;
  assign last_o  = last_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/board_cell_scanner.sv
// Registered board cell selector: direct requests
// or an automatic sweep, streamed out with index tags.
module board_cell_scanner
  import board_pkg::*;
#(
  parameter int NCELLS = NCELLS_DEF,
  parameter int WIDTH  = WIDTH_DEF,
  parameter int IDXW   = IDXW_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NCELLS*WIDTH-1:0] cells_in,
  input  logic [IDXW-1:0]         sel,
  input  logic                    sel_valid,
  output logic                    sel_ready,
  input  logic                    scan_start,
  input  logic                    scan_abort,
  output logic [WIDTH-1:0]        out_data,
  output logic [IDXW-1:0]         out_index,
  output logic                    out_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    scan_busy,
  output logic                    scan_done,
  output logic                    sel_err
);

  localparam logic [IDXW:0]   NC_W = (IDXW+1)'(NCELLS);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCELLS-1);

  scan_state_e state_q, state_d;
  logic [IDXW-1:0] cnt_q, cnt_d;
  logic done_q, done_d;
  logic err_q, err_d;

  logic can_load, dir_acc, sel_ok;
  logic scan_issue, abort_act;
  logic ld, ld_last;
  logic [IDXW-1:0]  ld_idx;
  logic [WIDTH-1:0] ld_data;

  assign scan_busy = (state_q != ST_IDLE);
  assign sel_ready = !scan_busy && can_load;
  assign dir_acc   = sel_valid && sel_ready;
  assign sel_ok    = {1'b0, sel} < NC_W;
  assign abort_act = scan_abort && scan_busy;

  assign scan_issue = (state_q == ST_SCAN) && can_load && !scan_abort;
  assign ld      = (dir_acc && sel_ok) || scan_issue;
  assign ld_idx  = scan_issue ? cnt_q : sel;
  assign ld_last = scan_issue && (cnt_q == LAST_IDX);
  assign err_d   = dir_acc && !sel_ok;

  always_comb begin
    ld_data = '0;
    for (int k = 0; k < NCELLS; k++) begin
      if (ld_idx == IDXW'(k)) ld_data = cells_in[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // a direct beat accepted this cycle wins over a sweep start
        if (scan_start && !dir_acc) begin
          state_d = ST_SCAN;
          cnt_d   = '0;
        end
      end
      ST_SCAN: begin
        if (scan_abort) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (scan_issue) begin
          if (ld_last) begin
            state_d = ST_DRAIN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (scan_abort) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (out_valid && out_ready && out_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign scan_done = done_q;
  assign sel_err   = err_q;

  board_out_reg #(
    .WIDTH(WIDTH),
    .IDXW (IDXW)
  ) u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (abort_act),
    .load_i    (ld),
    .data_i    (ld_data),
    .index_i   (ld_idx),
    .last_i    (ld_last),
    .ready_i   (out_ready),
    .data_o    (out_data),
    .index_o   (out_index),
    .last_o    (out_last),
    .valid_o   (out_valid),
    .can_load_o(can_load)
  );

endmodule

// File: tb/tb_board_cell_scanner.sv
// Scoreboard bench for board_cell_scanner: stimulus
// pushes expected beats, a monitor pops on handshake.
module tb_board_cell_scanner;

  localparam int NC = 9;
  localparam int W  = 8;
  localparam int IW = 4;

  typedef struct packed {
    logic [W-1:0]  d;
    logic [IW-1:0] i;
    logic          l;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [NC*W-1:0] cells_in;
  logic [IW-1:0] sel;
  logic sel_valid, sel_ready;
  logic scan_start, scan_abort;
  logic [W-1:0] out_data;
  logic [IW-1:0] out_index;
  logic out_last, out_valid, out_ready;
  logic scan_busy, scan_done, sel_err;

  int total = 0;
  int bad = 0;
  beat_t exp_q[$];
  logic prev_stall = 1'b0;
  beat_t prev_beat;

  always #5 clk = ~clk;

  board_cell_scanner #(.NCELLS(NC), .WIDTH(W), .IDXW(IW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cells_in  (cells_in),
    .sel       (sel),
    .sel_valid (sel_valid),
    .sel_ready (sel_ready),
    .scan_start(scan_start),
    .scan_abort(scan_abort),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .scan_busy (scan_busy),
    .scan_done (scan_done),
    .sel_err   (sel_err)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_sweep(int n);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.d = 8'h10 + 8'(k);
      b.i = IW'(k);
      b.l = (k == NC-1);
      exp_q.push_back(b);
    end
  endtask

  always @(negedge clk) begin
    beat_t cur;
    cur = '{d: out_data, i: out_index, l: out_last};
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_hold", 32'(cur), 32'(prev_beat));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got %0h want none", cur);
        end else begin
          chk("beat", 32'(cur), 32'(exp_q.pop_front()));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_beat  = cur;
    end
  end

  initial begin
    bit seen;
    rst_n = 1'b0;
    sel = '0;
    sel_valid = 1'b0;
    scan_start = 1'b0;
    scan_abort = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < NC; k++) cells_in[k*W +: W] = 8'h10 + 8'(k);
    #2;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_busy", 32'(scan_busy), 0);
    chk("rst_done", 32'(scan_done), 0);
    chk("rst_err", 32'(sel_err), 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // direct select
    sel = 4'd4;
    sel_valid = 1'b1;
    exp_q.push_back('{d: 8'h14, i: 4'd4, l: 1'b0});
    tick();
    chk("dir_valid", 32'(out_valid), 1);
    chk("dir_data", 32'(out_data), 32'h14);
    chk("dir_index", 32'(out_index), 4);
    chk("dir_last", 32'(out_last), 0);

    // out-of-range select
    sel = 4'd9;
    tick();
    sel_valid = 1'b0;
    chk("bad_err", 32'(sel_err), 1);
    chk("bad_valid", 32'(out_valid), 0);
    chk("bad_data", 32'(out_data), 32'h14);
    tick();
    chk("bad_err_pulse", 32'(sel_err), 0);

    // full sweep, no backpressure
    push_sweep(NC);
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    chk("sw_busy", 32'(scan_busy), 1);
    chk("sw_sel_ready", 32'(sel_ready), 0);
    tick();
    for (int k = 0; k < NC; k++) begin
      chk("sw_valid", 32'(out_valid), 1);
      chk("sw_index", 32'(out_index), 32'(k));
      tick();
    end
    chk("sw_done", 32'(scan_done), 1);
    chk("sw_idle", 32'(scan_busy), 0);
    tick();
    chk("sw_done_pulse", 32'(scan_done), 0);

    // sweep with random backpressure
    push_sweep(NC);
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
      if (scan_done) seen = 1'b1;
    end
    chk("bp_done_seen", 32'(seen), 1);
    chk("bp_q_empty", 32'(exp_q.size()), 0);
    out_ready = 1'b1;
    tick();

    // abort after beat 3
    push_sweep(4);
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    repeat (4) tick();
    chk("ab_beat3", 32'(out_index), 3);
    scan_abort = 1'b1;
    tick();
    scan_abort = 1'b0;
    chk("ab_valid", 32'(out_valid), 0);
    chk("ab_busy", 32'(scan_busy), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("ab_no_done", 32'(scan_done), 0);
    end
    chk("ab_q_empty", 32'(exp_q.size()), 0);

    // restart after abort begins at index 0
    push_sweep(NC);
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (scan_done) seen = 1'b1;
    end
    chk("rs_done_seen", 32'(seen), 1);
    chk("rs_q_empty", 32'(exp_q.size()), 0);

    // reset in the middle of a sweep
    push_sweep(NC);
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("mr_valid", 32'(out_valid), 0);
    chk("mr_data", 32'(out_data), 0);
    chk("mr_index", 32'(out_index), 0);
    chk("mr_busy", 32'(scan_busy), 0);
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mr_idle", 32'(scan_busy), 0);
      chk("mr_no_done", 32'(scan_done), 0);
      chk("mr_no_valid", 32'(out_valid), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
